lut_table_loader: RTL and testbench

//  Write side of a LogicNets LUT neuron: receives a neuron truth table as a serial beat stream and

---
 rtl/lut_table_loader.sv | 106 ++++++++++
 tb/tb_lut_table_loader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_table_loader.sv
// Loadable LUT neuron table: packs a serial beat stream into a 2^IN_BITS x OUT_BITS
// distributed-RAM table and serves registered lookups once the table is complete.
module lut_table_loader #(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 1,
  parameter int LOAD_W   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_start,
  input  logic                ld_valid,
  output logic                ld_ready,
  input  logic [LOAD_W-1:0]   ld_data,
  output logic                load_done,
  output logic                table_valid,
  input  logic                lk_valid,
  input  logic [IN_BITS-1:0]  lk_addr,
  output logic                lk_out_valid,
  output logic [OUT_BITS-1:0] lk_out
);

  localparam int DEPTH  = 2 ** IN_BITS;
  localparam int EPB    = LOAD_W / OUT_BITS;
  localparam int NBEATS = DEPTH / EPB;
  localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;

  // Handshake: a load beat transfers on a rising edge where ld_valid && ld_ready.
  // ld_ready is combinational and drops whenever load_start is high, so a restart
  // always wins over a beat presented in the same cycle. Lookups have no backpressure.

  logic [1:0]          state;
  logic [1:0]          state_next;
  logic [CW-1:0]       beat_cnt;
  logic                beat_fire;
  logic                last_beat;
  logic [IN_BITS-1:0]  beat_base;
  logic [OUT_BITS-1:0] mem [DEPTH];

  assign ld_ready  = (state == S_LOAD) && !load_start;
  assign beat_fire = ld_valid && ld_ready;
  assign last_beat = (beat_cnt == CW'(NBEATS - 1));
  assign beat_base = IN_BITS'(beat_cnt) * IN_BITS'(EPB);

  always_comb begin
    state_next = state;
    if (load_start) begin
      state_next = S_LOAD;
    end else begin
      case (state)
        S_IDLE:   state_next = S_IDLE;
        S_LOAD:   if (beat_fire && last_beat) state_next = S_ACTIVE;
        S_ACTIVE: state_next = S_ACTIVE;
        default:  state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      beat_cnt    <= '0;
      load_done   <= 1'b0;
      table_valid <= 1'b0;
    end else begin
      state     <= state_next;
      load_done <= beat_fire && last_beat;
      if (load_start) begin
        beat_cnt    <= '0;
        table_valid <= 1'b0;
      end else if (beat_fire) begin
        if (last_beat) begin
          table_valid <= 1'b1;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
    end
  end

  // Table storage is deliberately unreset so it maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (beat_fire) begin
      for (int k = 0; k < EPB; k++) begin
        mem[beat_base + IN_BITS'(k)] <= ld_data[k*OUT_BITS +: OUT_BITS];
      end
    end
  end

  // Lookups issued while the table is incomplete are dropped; lk_out keeps its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lk_out_valid <= 1'b0;
      lk_out       <= '0;
    end else begin
      lk_out_valid <= table_valid && lk_valid;
      if (table_valid && lk_valid) begin
        lk_out <= mem[lk_addr];
      end
    end
  end

endmodule

// File: tb/tb_lut_table_loader.sv
// Directed-plus-random bench for lut_table_loader: a reference table built from the
// beat packing rule, with a lookup result queue as scoreboard.
module tb_lut_table_loader;

  localparam int IN_BITS  = 8;
  localparam int OUT_BITS = 1;
  localparam int LOAD_W   = 8;
  localparam int DEPTH    = 256;
  localparam int NBEATS   = 32;

  logic                clk;
  logic                rst_n;
  logic                load_start;
  logic                ld_valid;
  logic                ld_ready;
  logic [LOAD_W-1:0]   ld_data;
  logic                load_done;
  logic                table_valid;
  logic                lk_valid;
  logic [IN_BITS-1:0]  lk_addr;
  logic                lk_out_valid;
  logic [OUT_BITS-1:0] lk_out;

  int checks   = 0;
  int failures = 0;

  logic [OUT_BITS-1:0] exp_table [DEPTH];
  logic [OUT_BITS-1:0] exp_q[$];
  logic [OUT_BITS-1:0] last_lk;
  int                  beat_idx;

  lut_table_loader #(
    .IN_BITS (IN_BITS),
    .OUT_BITS(OUT_BITS),
    .LOAD_W  (LOAD_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_start  (load_start),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_data     (ld_data),
    .load_done   (load_done),
    .table_valid (table_valid),
    .lk_valid    (lk_valid),
    .lk_addr     (lk_addr),
    .lk_out_valid(lk_out_valid),
    .lk_out      (lk_out)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] beat_value(input int mode, input int b);
    case (mode)
      0:       return 8'hA5 ^ 8'(b);
      1:       return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic start_load();
    load_start = 1'b1;
    ld_valid   = 1'b1;
    ld_data    = 8'($urandom);
    #1;
    check("ld_ready_during_start", 32'(ld_ready), 32'd0);
    tick();
    load_start = 1'b0;
    ld_valid   = 1'b0;
    beat_idx   = 0;
    check("table_valid_after_start", 32'(table_valid), 32'd0);
    check("load_done_after_start", 32'(load_done), 32'd0);
    #1;
    check("ld_ready_in_load", 32'(ld_ready), 32'd1);
  endtask

  // Offers n beats of the given pattern; lookups are issued throughout and must be dropped.
  task automatic send_beats(input int mode, input int n, input bit gaps);
    int         sent;
    int         budget;
    bit         fin;
    logic [7:0] d;
    sent   = 0;
    budget = 0;
    d      = beat_value(mode, beat_idx);
    while (sent < n && budget < 1000) begin
      ld_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      ld_data  = ld_valid ? d : 8'($urandom);
      lk_valid = 1'b1;
      lk_addr  = 8'($urandom);
      #1;
      check("ld_ready_load", 32'(ld_ready), 32'd1);
      fin = ld_valid && (beat_idx == NBEATS - 1);
      tick();
      if (ld_valid) begin
        for (int k = 0; k < 8; k++) exp_table[beat_idx*8 + k] = d[k];
        beat_idx++;
        sent++;
        d = beat_value(mode, beat_idx);
      end
      check("load_done", 32'(load_done), 32'(fin));
      check("table_valid_load", 32'(table_valid), 32'(fin));
      check("lk_dropped_valid", 32'(lk_out_valid), 32'd0);
      check("lk_dropped_hold", 32'(lk_out), 32'(last_lk));
      budget++;
    end
    if (budget >= 1000) begin
      checks++;
      failures++;
      $error("FAIL beat_budget observed=%0d expected=%0d", sent, n);
    end
    ld_valid = 1'b0;
    lk_valid = 1'b0;
    if (beat_idx == NBEATS) begin
      #1;
      check("ld_ready_after_final", 32'(ld_ready), 32'd0);
      tick();
      check("load_done_fall", 32'(load_done), 32'd0);
      check("table_valid_held", 32'(table_valid), 32'd1);
    end
  endtask

  task automatic sweep(input bit random_order);
    logic [7:0]          a;
    logic [OUT_BITS-1:0] e;
    for (int i = 0; i < DEPTH; i++) begin
      a        = random_order ? 8'($urandom_range(0, 255)) : 8'(i);
      lk_valid = 1'b1;
      lk_addr  = a;
      exp_q.push_back(exp_table[a]);
      tick();
      check("lk_out_valid", 32'(lk_out_valid), 32'd1);
      e = exp_q.pop_front();
      check("lk_out", 32'(lk_out), 32'(e));
      last_lk = e;
    end
    lk_valid = 1'b0;
    tick();
    check("lk_idle_valid", 32'(lk_out_valid), 32'd0);
    check("lk_idle_hold", 32'(lk_out), 32'(last_lk));
  endtask

  initial begin
    logic [7:0] r;
    rst_n      = 1'b0;
    load_start = 1'b0;
    ld_valid   = 1'b1;
    ld_data    = 8'h00;
    lk_valid   = 1'b1;
    lk_addr    = 8'h00;
    last_lk    = '0;
    beat_idx   = 0;

    // 1: reset with valids asserted
    repeat (3) tick();
    check("rst_ld_ready", 32'(ld_ready), 32'd0);
    check("rst_table_valid", 32'(table_valid), 32'd0);
    check("rst_lk_out_valid", 32'(lk_out_valid), 32'd0);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_lk_out", 32'(lk_out), 32'd0);
    rst_n = 1'b1;

    // 5 (IDLE part): requests in IDLE are dropped, no beats accepted
    repeat (3) begin
      lk_addr = 8'($urandom);
      tick();
      check("idle_lk_out_valid", 32'(lk_out_valid), 32'd0);
      check("idle_ld_ready", 32'(ld_ready), 32'd0);
    end
    ld_valid = 1'b0;
    lk_valid = 1'b0;

    // 2: full load of 8'hA5 ^ b, sequential sweep
    start_load();
    send_beats(0, NBEATS, 1'b0);
    sweep(1'b0);

    // 3: random gaps on ld_valid, same contents, random-order lookups
    start_load();
    send_beats(0, NBEATS, 1'b1);
    sweep(1'b1);

    // 4: restart after 10 beats, then 32 beats of 8'hFF
    start_load();
    send_beats(2, 10, 1'b0);
    start_load();
    send_beats(1, NBEATS, 1'b1);
    sweep(1'b1);

    // 6: lookup in t, load_start in t+1
    r        = 8'($urandom);
    lk_valid = 1'b1;
    lk_addr  = r;
    tick();
    load_start = 1'b1;
    lk_valid   = 1'b0;
    check("reload_inflight_valid", 32'(lk_out_valid), 32'd1);
    check("reload_inflight_data", 32'(lk_out), 32'(exp_table[r]));
    last_lk = exp_table[r];
    tick();
    load_start = 1'b0;
    beat_idx   = 0;
    check("reload_table_valid", 32'(table_valid), 32'd0);
    check("reload_lk_out_valid", 32'(lk_out_valid), 32'd0);
    send_beats(2, NBEATS, 1'b1);
    sweep(1'b1);

    // reset mid-load returns to IDLE
    start_load();
    send_beats(2, 5, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_ld_ready", 32'(ld_ready), 32'd0);
    check("midrst_table_valid", 32'(table_valid), 32'd0);
    check("midrst_lk_out", 32'(lk_out), 32'd0);
    last_lk = '0;
    tick();
    rst_n    = 1'b1;
    ld_valid = 1'b1;
    repeat (3) begin
      tick();
      check("post_rst_ld_ready", 32'(ld_ready), 32'd0);
      check("post_rst_table_valid", 32'(table_valid), 32'd0);
    end
    ld_valid = 1'b0;
    start_load();
    send_beats(0, NBEATS, 1'b0);
    sweep(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
